// File: rtl/ps2_transmitter_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
// Holds the FSM state encoding, default timing parameters, the clock filter width
// and the parity helper. Imported by the transmitter and its clock filter.
package ps2_transmitter_pkg;

  // Shift filter length on the raw PS/2 clock pin.
  localparam int unsigned FilterWidth = 8;

  // Defaults sized for a 50 MHz system clock: 120 us inhibit, 15 ms edge timeout.
  localparam int unsigned DefaultInhibitCycles = 6000;
  localparam int unsigned DefaultTimeoutCycles = 750000;

  // Shared inhibit/timeout counter width.
  localparam int unsigned CntWidth = 20;

  // {stop, parity, data[7:0]}
  localparam int unsigned FrameWidth = 10;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRts      = 3'd1,
    StStart    = 3'd2,
    StData     = 3'd3,
    StStop     = 3'd4,
    StWaitIdle = 3'd5
  } tx_state_e;

  // PS/2 uses odd parity over the 8 data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_transmitter_clk_filter.sv
// PS/2 clock pin filter and falling-edge detector.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   ps2c_i       raw PS/2 clock pin level
//   ps2c_f_o     filtered clock level (registered)
//   neg_edge_o   high in the cycle the filtered level is about to go 1 -> 0
module ps2_transmitter_clk_filter
  import ps2_transmitter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ps2c_i,
  output logic ps2c_f_o,
  output logic neg_edge_o
);

  logic [FilterWidth-1:0] filter_q, filter_d;
  logic                   f_q, f_d;

  // The filtered level only moves once the whole window agrees; mixed windows hold it.
  always_comb begin
    filter_d = {ps2c_i, filter_q[FilterWidth-1:1]};
    f_d      = f_q;
    if (&filter_d) begin
      f_d = 1'b1;
    end else if (~|filter_d) begin
      f_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filter_q <= '0;
      f_q      <= 1'b0;
    end else begin
      filter_q <= filter_d;
      f_q      <= f_d;
    end
  end

  assign ps2c_f_o   = f_q;
  assign neg_edge_o = f_q & ~f_d;

endmodule

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device transmitter: request-to-send inhibit, 8 data bits, odd parity
// and stop clocked out on device falling edges, then the device acknowledge check.
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   wr_ps2_i          one-cycle send request (ignored unless idle)
//   din_i             byte to send, latched on accept
//   ps2c_i, ps2d_i    raw PS/2 clock/data pin levels
//   ps2c_oe_o         1 = pull clock low
//   ps2d_oe_o         1 = pull data low
//   tx_idle_o         1 while idle (gates the receiver)
//   tx_done_tick_o    pulse: frame sent and acknowledged
//   tx_err_tick_o     pulse: NACK or edge timeout
module ps2_transmitter
  import ps2_transmitter_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DefaultInhibitCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2_i,
  input  logic [7:0] din_i,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic       ps2c_oe_o,
  output logic       ps2d_oe_o,
  output logic       tx_idle_o,
  output logic       tx_done_tick_o,
  output logic       tx_err_tick_o
);

  localparam logic [CntWidth-1:0] InhibitLast = CntWidth'(INHIBIT_CYCLES - 1);
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TIMEOUT_CYCLES - 1);
  localparam logic [CntWidth-1:0] TimeoutSat  = CntWidth'(TIMEOUT_CYCLES);

  tx_state_e             state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [3:0]            bit_cnt_q;
  logic [3:0]            bit_nxt;
  logic [FrameWidth-1:0] frame_q;
  logic                  nack_q;
  logic                  ps2c_oe_q, ps2d_oe_q, tx_idle_q, done_q, err_q;
  logic                  ps2c_f, neg_edge;

  ps2_transmitter_clk_filter u_clk_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2c_i    (ps2c_i),
    .ps2c_f_o  (ps2c_f),
    .neg_edge_o(neg_edge)
  );

  assign bit_nxt = bit_cnt_q + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      nack_q    <= 1'b0;
      ps2c_oe_q <= 1'b0;
      ps2d_oe_q <= 1'b0;
      tx_idle_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wr_ps2_i) begin
            frame_q   <= {1'b1, odd_parity(din_i), din_i};
            cnt_q     <= '0;
            ps2c_oe_q <= 1'b1;
            tx_idle_q <= 1'b0;
            state_q   <= StRts;
          end
        end
        StRts: begin
          if (cnt_q == InhibitLast) begin
            // Release clock and pull data low together: this is the start bit.
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StStart;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStart, StData, StStop, StWaitIdle: begin
          if (state_q == StWaitIdle && ps2c_f && ps2d_i) begin
            done_q    <= ~nack_q;
            err_q     <= nack_q;
            tx_idle_q <= 1'b1;
            state_q   <= StIdle;
          end else if (neg_edge) begin
            cnt_q <= '0;
            if (state_q == StStart) begin
              ps2d_oe_q <= ~frame_q[0];
              bit_cnt_q <= '0;
              state_q   <= StData;
            end else if (state_q == StData) begin
              // bit_cnt_q == 8 means parity is on the line; this edge puts stop out.
              if (bit_cnt_q == 4'd8) begin
                ps2d_oe_q <= 1'b0;
                state_q   <= StStop;
              end else begin
                bit_cnt_q <= bit_nxt;
                ps2d_oe_q <= ~frame_q[bit_nxt];
              end
            end else if (state_q == StStop) begin
              nack_q  <= ps2d_i;
              state_q <= StWaitIdle;
            end
          end else if (cnt_q == TimeoutLast) begin
            cnt_q     <= TimeoutSat;
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= 1'b0;
            err_q     <= 1'b1;
            tx_idle_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          ps2c_oe_q <= 1'b0;
          ps2d_oe_q <= 1'b0;
          tx_idle_q <= 1'b1;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign ps2c_oe_o      = ps2c_oe_q;
  assign ps2d_oe_o      = ps2d_oe_q;
  assign tx_idle_o      = tx_idle_q;
  assign tx_done_tick_o = done_q;
  assign tx_err_tick_o  = err_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: open-collector line model, a device that clocks and
// samples the frame, and a per-cycle check of the request-to-send window.
module tb_ps2_transmitter;

  localparam int unsigned Inhibit = 64;
  localparam int unsigned Timeout = 1000;
  localparam int          Half    = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2c, ps2d;
  logic       c_oe, d_oe, idle, done, err;

  // Wired-AND open-collector lines with pull-ups.
  assign ps2c = ~(c_oe | dev_clk_low);
  assign ps2d = ~(d_oe | dev_dat_low);

  ps2_transmitter #(
    .INHIBIT_CYCLES(Inhibit),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_ps2_i      (wr),
    .din_i         (din),
    .ps2c_i        (ps2c),
    .ps2d_i        (ps2d),
    .ps2c_oe_o     (c_oe),
    .ps2d_oe_o     (d_oe),
    .tx_idle_o     (idle),
    .tx_done_tick_o(done),
    .tx_err_tick_o (err)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass = 0;
  logic chk_en = 1'b0;
  logic expect_accept = 1'b0;
  int   rts_left = 0;
  logic rts_end = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model of the inhibit window: clock pulled low for exactly Inhibit cycles after an
  // accepted request, start bit appears as the window closes.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rts_left = 0;
      rts_end  = 1'b0;
    end else begin
      rts_end = (rts_left == 1);
      if (wr && expect_accept) rts_left = Inhibit;
      else if (rts_left > 0) rts_left--;
    end
  end

  always @(negedge clk) begin
    if (!reset && chk_en) begin
      check("clk_pull", {31'd0, c_oe}, {31'd0, rts_left > 0});
      if (rts_left > 0) begin
        check("rts_busy", {31'd0, idle}, 32'd0);
        check("rts_data", {31'd0, d_oe}, 32'd0);
      end
      if (rts_end) check("start_drive", {31'd0, d_oe}, 32'd1);
      if (done || err) check("tick_idle", {31'd0, idle}, 32'd1);
      check("tick_excl", {31'd0, done & err}, 32'd0);
    end
  end

  task automatic send(input logic [7:0] b);
    din = b;
    expect_accept = 1'b1;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    expect_accept = 1'b0;
  endtask

  task automatic wait_tick(input int limit, output int cyc, output logic gd, output logic ge);
    cyc = 0;
    gd = 1'b0;
    ge = 1'b0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (done || err) begin
        gd = done;
        ge = err;
        break;
      end
    end
  endtask

  // Device side: waits for the start bit, then 11 clock pulses; samples data on rising edges.
  task automatic device_frame(input logic do_ack, input int mid_wr_edge, input int abort_edge,
                              output logic [9:0] bits, output logic aborted);
    int c;
    int w;
    c = 0;
    w = 0;
    bits = '0;
    aborted = 1'b0;
    while (!(d_oe && !c_oe) && w < int'(Inhibit) + 20) begin
      if (c_oe) c++;
      @(negedge clk);
      w++;
    end
    check("rts_hold", c, Inhibit);
    check("start_seen", {31'd0, d_oe & ~c_oe}, 32'd1);
    if (!(d_oe && !c_oe)) begin
      aborted = 1'b1;
      return;
    end
    check("start_bit", {31'd0, ps2d}, 32'd0);
    repeat (Half) @(negedge clk);
    for (int e = 0; e < 11; e++) begin
      dev_clk_low = 1'b1;
      if (e == mid_wr_edge) begin
        din = 8'h55;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        repeat (Half - 1) @(negedge clk);
      end else begin
        repeat (Half) @(negedge clk);
      end
      if (e == abort_edge) begin
        aborted = 1'b1;
        return;
      end
      dev_clk_low = 1'b0;
      if (e < 10) bits[e] = ps2d;
      if (e == 9 && do_ack) dev_dat_low = 1'b1;
      if (e == 10) begin
        dev_dat_low = 1'b0;
        return;
      end
      repeat (Half) @(negedge clk);
    end
  endtask

  // Expected frame from the protocol rules: LSB-first data, odd parity, stop high.
  task automatic check_frame(input string name, input logic [7:0] b, input logic [9:0] bits);
    check({name, "_data"}, {24'd0, bits[7:0]}, {24'd0, b});
    check({name, "_parity"}, {31'd0, bits[8]}, {31'd0, ($countones(b) % 2) == 0});
    check({name, "_stop"}, {31'd0, bits[9]}, 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    logic       ab, gd, ge, seen;
    int         cyc, w;

    repeat (3) @(negedge clk);
    check("rst_c_oe", {31'd0, c_oe}, 32'd0);
    check("rst_d_oe", {31'd0, d_oe}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (20) @(negedge clk);

    // 0xED with ACK; literal pins: LSB-first 1,0,1,1,0,1,1,1 and parity 1.
    send(8'hED);
    device_frame(1'b1, -1, -1, bits, ab);
    check_frame("ed", 8'hED, bits);
    check("ed_lit_bits", {24'd0, bits[7:0]}, 32'h0000_00ED);
    check("ed_lit_par", {31'd0, bits[8]}, 32'd1);
    wait_tick(200, cyc, gd, ge);
    check("ed_done", {31'd0, gd}, 32'd1);
    check("ed_err", {31'd0, ge}, 32'd0);
    check("ed_idle", {31'd0, idle}, 32'd1);

    // Back-to-back: request in the cycle right after the done tick.
    send(8'hF4);
    device_frame(1'b1, -1, -1, bits, ab);
    check_frame("f4", 8'hF4, bits);
    check("f4_lit_par", {31'd0, bits[8]}, 32'd0);
    wait_tick(200, cyc, gd, ge);
    check("f4_done", {31'd0, gd}, 32'd1);
    check("f4_err", {31'd0, ge}, 32'd0);

    repeat (10) @(negedge clk);
    send(8'h00);
    device_frame(1'b1, -1, -1, bits, ab);
    check_frame("z", 8'h00, bits);
    check("z_lit_par", {31'd0, bits[8]}, 32'd1);
    wait_tick(200, cyc, gd, ge);
    check("z_done", {31'd0, gd}, 32'd1);

    // NACK: device leaves data high at the ack edge.
    repeat (10) @(negedge clk);
    send(8'hA5);
    device_frame(1'b0, -1, -1, bits, ab);
    check_frame("nack", 8'hA5, bits);
    wait_tick(200, cyc, gd, ge);
    check("nack_err", {31'd0, ge}, 32'd1);
    check("nack_done", {31'd0, gd}, 32'd0);
    check("nack_idle", {31'd0, idle}, 32'd1);

    // Request with 0x55 mid-frame must be ignored.
    repeat (10) @(negedge clk);
    send(8'hED);
    device_frame(1'b1, 3, -1, bits, ab);
    check_frame("mid", 8'hED, bits);
    wait_tick(200, cyc, gd, ge);
    check("mid_done", {31'd0, gd}, 32'd1);

    // Timeout: the device never clocks after the start bit.
    repeat (10) @(negedge clk);
    send(8'h3C);
    w = 0;
    while (!(d_oe && !c_oe) && w < int'(Inhibit) + 20) begin
      @(negedge clk);
      w++;
    end
    check("to_start", {31'd0, d_oe & ~c_oe}, 32'd1);
    wait_tick(Timeout + 50, cyc, gd, ge);
    check("to_cycles", cyc, Timeout);
    check("to_err", {31'd0, ge}, 32'd1);
    check("to_done", {31'd0, gd}, 32'd0);
    check("to_c_oe", {31'd0, c_oe}, 32'd0);
    check("to_d_oe", {31'd0, d_oe}, 32'd0);

    // Asynchronous reset in the middle of the data bits.
    repeat (10) @(negedge clk);
    send(8'hED);
    device_frame(1'b1, -1, 4, bits, ab);
    check("rst_aborted", {31'd0, ab}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_c_oe", {31'd0, c_oe}, 32'd0);
    check("arst_d_oe", {31'd0, d_oe}, 32'd0);
    check("arst_idle", {31'd0, idle}, 32'd1);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | done | err;
    end
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | done | err;
    end
    check("arst_no_tick", {31'd0, seen}, 32'd0);
    send(8'hF4);
    device_frame(1'b1, -1, -1, bits, ab);
    check_frame("post", 8'hF4, bits);
    wait_tick(200, cyc, gd, ge);
    check("post_done", {31'd0, gd}, 32'd1);
    check("post_err", {31'd0, ge}, 32'd0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_transmitter.md
# ps2_transmitter

Host-to-device PS/2 transmitter. It sends one command byte (for example LED set `0xED` or enable `0xF4`) to a keyboard or mouse over the open-collector PS/2 clock and data lines. It runs the request-to-send inhibit, shifts out 8 data bits, odd parity and stop on device-generated clock edges, then checks the device acknowledge. It sits beside the PS/2 receiver and shares the same `ps2c`/`ps2d` pins. `tx_idle` gates the receiver's receive enable.

## Interface
- `INHIBIT_CYCLES`, default 6000: clock-low hold time for request-to-send (120 µs at 50 MHz). Must be ≥ 16.
- `TIMEOUT_CYCLES`, default 750000: maximum `clk` cycles allowed between device clock falling edges (15 ms at 50 MHz).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `wr_ps2`  in  1  one-cycle request to send `din`.
- `din`  in  8  byte to send; latched when `wr_ps2` is accepted.
- `ps2c`  in  1  raw PS/2 clock pin level.
- `ps2d`  in  1  raw PS/2 data pin level.
- `ps2c_oe`  out  1  1 = pull clock low; 0 = release. Top level drives `ps2c` to 0 when this is 1, else high-Z.
- `ps2d_oe`  out  1  1 = pull data low; 0 = release.
- `tx_idle`  out  1  1 when in IDLE.
- `tx_done_tick`  out  1  one-cycle pulse: byte sent and ACK received.
- `tx_err_tick`  out  1  one-cycle pulse: NACK or timeout.

## Operation
- Clock filtering and edge detect:
  - 8-bit shift filter on `ps2c`. Filtered value goes to 1 on all-ones, to 0 on all-zeros, otherwise holds.
  - `neg_edge` = filtered value is 1 now and 0 next.
- Frame register `{1'b1 stop, odd parity, din[7:0]}`, loaded at accept.
  - Parity = ~^din.
- States and transitions:
  - IDLE: both oe = 0. `wr_ps2` → latch frame, clear counter, go to RTS.
  - RTS: `ps2c_oe`=1. When counter reaches INHIBIT_CYCLES−1 → set `ps2d_oe`=1 (start bit), `ps2c_oe`=0, go to START.
  - START: wait for `neg_edge`, then drive bit0 (`ps2d_oe` = ~bit), set bit count to 0, go to DATA.
    - The filter reads 0 after RTS, so the first `neg_edge` seen is device-generated.
  - DATA: on each `neg_edge`, advance and drive the next frame bit.
    - After parity is driven, the next `neg_edge` drives stop (`ps2d_oe`=0) → STOP.
  - STOP: on `neg_edge`, sample `ps2d` into the ack flag (0 = ACK) → WAIT_IDLE.
  - WAIT_IDLE: when filtered clock = 1 and `ps2d` = 1:
    - ACK → `tx_done_tick`;
    - NACK → `tx_err_tick`;
    - then go to IDLE.
- Timeout:
  - Counter clears on each `neg_edge` and on entry to START.
  - In START, DATA, STOP or WAIT_IDLE, reaching TIMEOUT_CYCLES → both oe = 0, `tx_err_tick`, go to IDLE.
- `wr_ps2` outside IDLE is ignored; `din` is not re-latched.
- Reset mid-frame releases both lines immediately (async) and enters IDLE. No tick is issued.

## Timing
- Reset values:
  - `ps2c_oe`=0, `ps2d_oe`=0;
  - `tx_idle`=1;
  - `tx_done_tick`=0, `tx_err_tick`=0;
  - state IDLE, counters 0.
- All outputs are registered.
- Request to line activity:
  - `ps2c_oe` rises the cycle after `wr_ps2`.
  - `tx_idle` falls in that same cycle.
  - Clock is held low exactly INHIBIT_CYCLES cycles.
  - `ps2d_oe` rises and `ps2c_oe` falls in the same cycle.
- Each data/parity/stop change appears one cycle after the `neg_edge` cycle. Filter latency from pin to `neg_edge` is about 9 cycles.
- Exactly 11 device falling edges per frame: 8 data, parity, stop, ack.
- Tick to idle:
  - `tx_idle` returns to 1 in the same cycle as the done/error tick.
  - A new `wr_ps2` is accepted the following cycle.
- Counter is 20 bits wide and saturates on timeout; no wrap-around.

## Structure
- Shared include `ps2_defs.vh`:
  - state encodings;
  - default INHIBIT_CYCLES and TIMEOUT_CYCLES;
  - filter width (8).
- Sub-module `ps2_clk_filter`: input `ps2c`; outputs filtered level and `neg_edge`. Reusable by the receiver.

## Test plan
- `din`=0xED with a device model clocking at 12.5 kHz:
  - clock held low 6000 cycles;
  - data bits 1,0,1,1,0,1,1,1, parity 1, stop released;
  - device ACK → one `tx_done_tick`, `tx_idle`=1.
- `din`=0xF4: parity bit 0. `din`=0x00: parity 1. Data line observed correct at each device rising edge.
- Device leaves data high at the ack edge → `tx_err_tick`, no `tx_done_tick`.
- Device never clocks after RTS → `tx_err_tick` exactly TIMEOUT_CYCLES after START entry; both oe = 0.
- `wr_ps2` pulsed with `din`=0x55 mid-frame of 0xED → ignored; frame continues as 0xED.
- Async reset asserted during DATA:
  - `ps2c_oe`/`ps2d_oe` drop immediately, no tick;
  - next `wr_ps2` runs a clean frame.
